user_sched_ctrl: RTL

Round-robin scheduler that sequences pending user entries in the 16-entry user RAM through the server FSM / operation unit pipeline, one transaction at a time. It reads the entry and issues `start`/`frame` to the server. It then waits for the authentication result and the processed write-back, and commits the result into the RAM. Stuck transactions are retired by a timeout so one bad user cannot stall the system.

---
 rtl/user_sched_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/user_sched_ctrl.sv
// Round-robin user scheduler. Picks the next pending RAM entry after the
// last one served, reads it, issues it to the server FSM, waits for the
// authentication result and the processed write-back, then commits the
// payload and retires the entry. A per-wait-state timeout retires stuck
// transactions so one bad user cannot stall the rest.
module user_sched_ctrl #(
  parameter  int ENTRIES     = 16,
  parameter  int TIMEOUT_CYC = 64,
  localparam int AW          = $clog2(ENTRIES),
  localparam int CW          = $clog2(TIMEOUT_CYC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] pending,
  output logic [AW-1:0]      rd_addr,
  input  logic [15:0]        rd_data,
  output logic               start,
  output logic [15:0]        frame,
  input  logic               auth_done,
  input  logic               auth_fail,
  input  logic               wb_valid,
  input  logic [7:0]         wb_data,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [7:0]         wr_data,
  output logic               done,
  output logic [AW-1:0]      done_addr,
  output logic               done_ok,
  output logic               timeout,
  output logic               busy,
  output logic [7:0]         fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_WAIT_AUTH,
    S_WAIT_WB,
    S_RETIRE
  } state_t;

  // Failure counter sticks at its maximum instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_cur;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_rd_addr;
  logic          r_start;
  logic [15:0]   r_frame;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_done;
  logic [AW-1:0] r_done_addr;
  logic          r_done_ok;
  logic          r_timeout;
  logic          r_busy;
  logic [7:0]    r_fail_cnt;

  state_t        w_state_nxt;
  logic [AW-1:0] w_ptr_nxt;
  logic [AW-1:0] w_cur_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_rd_addr_nxt;
  logic          w_start_nxt;
  logic [15:0]   w_frame_nxt;
  logic          w_wr_en_nxt;
  logic [AW-1:0] w_wr_addr_nxt;
  logic [7:0]    w_wr_data_nxt;
  logic          w_done_nxt;
  logic [AW-1:0] w_done_addr_nxt;
  logic          w_done_ok_nxt;
  logic          w_timeout_nxt;
  logic [7:0]    w_fail_cnt_nxt;
  logic          w_retire;
  logic          w_ret_ok;
  logic          w_ret_to;
  logic          w_expire;
  logic          w_found;
  logic [AW-1:0] w_sel;
  logic [AW-1:0] w_idx;

  // Last cycle allowed in a wait state; a response on this cycle still wins
  assign w_expire = (r_cnt == CW'(TIMEOUT_CYC - 1));

  // Round-robin pick: first set pending bit at ptr+1, ptr+2, ... (mod ENTRIES)
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_idx = r_ptr + AW'(i + 1);
      if (!w_found && pending[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Next-state and next-output decode; retirement is shared by all exits
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cur_nxt       = r_cur;
    w_cnt_nxt       = r_cnt;
    w_rd_addr_nxt   = r_rd_addr;
    w_start_nxt     = 1'b0;
    w_frame_nxt     = r_frame;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_done_nxt      = 1'b0;
    w_done_addr_nxt = r_done_addr;
    w_done_ok_nxt   = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_fail_cnt_nxt  = r_fail_cnt;
    w_retire        = 1'b0;
    w_ret_ok        = 1'b0;
    w_ret_to        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_rd_addr_nxt = w_sel;
          w_cur_nxt     = w_sel;
          w_state_nxt   = S_READ;
        end
      end
      S_READ: begin
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // frame is captured once here and held until the next issue
        w_frame_nxt = rd_data;
        w_start_nxt = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_AUTH;
      end
      S_WAIT_AUTH: begin
        if (auth_fail) begin
          w_retire = 1'b1;
        end else if (auth_done) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_WB;
        end else if (w_expire) begin
          w_retire = 1'b1;
          w_ret_to = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_WB: begin
        if (wb_valid) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_cur;
          w_wr_data_nxt = wb_data;
          w_retire      = 1'b1;
          w_ret_ok      = 1'b1;
        end else if (w_expire) begin
          w_retire = 1'b1;
          w_ret_to = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RETIRE: begin
        w_ptr_nxt   = r_cur;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // done is visible during RETIRE so the requester drops pending before IDLE
    if (w_retire) begin
      w_state_nxt     = S_RETIRE;
      w_done_nxt      = 1'b1;
      w_done_addr_nxt = r_cur;
      w_done_ok_nxt   = w_ret_ok;
      w_timeout_nxt   = w_ret_to;
      if (!w_ret_ok) begin
        w_fail_cnt_nxt = sat_inc8(r_fail_cnt);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and transaction context
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= AW'(ENTRIES - 1);
      r_cur       <= '0;
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_start     <= 1'b0;
      r_frame     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_done      <= 1'b0;
      r_done_addr <= '0;
      r_done_ok   <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_fail_cnt  <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_cur       <= w_cur_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_start     <= w_start_nxt;
      r_frame     <= w_frame_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_done      <= w_done_nxt;
      r_done_addr <= w_done_addr_nxt;
      r_done_ok   <= w_done_ok_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_fail_cnt  <= w_fail_cnt_nxt;
    end
  end

  assign rd_addr   = r_rd_addr;
  assign start     = r_start;
  assign frame     = r_frame;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign done      = r_done;
  assign done_addr = r_done_addr;
  assign done_ok   = r_done_ok;
  assign timeout   = r_timeout;
  assign busy      = r_busy;
  assign fail_cnt  = r_fail_cnt;

endmodule
